// File: rtl/led_matrix_pkg.sv
// Shared types for the LED matrix pixel path.
// Phase and fill-state enums plus frame size helper.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    P0,
    P1,
    P2
  } phase_e;

  typedef enum logic [1:0] {
    FILL_WAIT,
    FILL,
    FULL
  } fill_e;

  function automatic int num_pix(input int rows,
                                 input int cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/led_matrix_pixel_unpacker.sv
// Host byte stream -> one RGB pixel per valid cycle, with frame tracking.
// In: clk rst byte_valid/data/sof err_clr. Out: pix_valid/rgb/sync frame_done err_short/long.
module led_matrix_pixel_unpacker
  import led_matrix_pkg::*;
#(
  parameter int PANEL_ROWS  = 64,
  parameter int PANEL_COLS  = 64,
  parameter int COLOR_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  input  logic                         byte_sof,
  input  logic                         err_clr,
  output logic                         pix_valid,
  output logic [2:0][COLOR_DEPTH-1:0]  pix_rgb,
  output logic                         pix_sync,
  output logic                         frame_done,
  output logic                         err_short,
  output logic                         err_long
);

  localparam int N  = num_pix(PANEL_ROWS, PANEL_COLS);
  localparam int CW = $clog2(N + 1);
  localparam int CD = COLOR_DEPTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef logic [2:0][CD-1:0] rgb_t;

  phase_e         phase_q, phase_d, ph;
  fill_e          st_q, st_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_e;
  logic [CD-1:0]  hr_q, hr_d;
  logic [CD-1:0]  hg_q, hg_d;
  logic           sof, acc, emit;
  rgb_t           emit_rgb;
  logic           set_short, set_long;

  logic           valid_q, sync_q, done_q;
  rgb_t           rgb_q;
  logic           eshort_q, eshort_d;
  logic           elong_q, elong_d;

  // A SOF byte restarts the frame in place and is itself the P0 byte.
  assign sof   = byte_valid & byte_sof;
  assign acc   = sof | (byte_valid & (st_q == FILL));
  assign ph    = sof ? P0 : phase_q;
  assign cnt_e = sof ? '0 : cnt_q;

  generate
    if (!(CD == 4 || CD == 8)) begin : g_bad_cd
      $error("COLOR_DEPTH must be 4 or 8");
    end

    if (CD == 4) begin : g_cd4
      // 3 bytes carry 2 pixels; px1's red nibble rides in byte P1.
      always_comb begin
        emit     = 1'b0;
        emit_rgb = '0;
        hr_d     = hr_q;
        hg_d     = hg_q;
        if (acc) begin
          unique case (ph)
            P0: begin
              hr_d = byte_data[7:4];
              hg_d = byte_data[3:0];
            end
            P1: begin
              emit     = 1'b1;
              emit_rgb = {hr_q, hg_q, byte_data[7:4]};
              hr_d     = byte_data[3:0];
            end
            P2: begin
              emit     = 1'b1;
              emit_rgb = {hr_q, byte_data[7:4],
                          byte_data[3:0]};
            end
            default: ;
          endcase
        end
      end
    end else begin : g_cd8
      always_comb begin
        emit     = 1'b0;
        emit_rgb = '0;
        hr_d     = hr_q;
        hg_d     = hg_q;
        if (acc) begin
          unique case (ph)
            P0: hr_d = byte_data[CD-1:0];
            P1: hg_d = byte_data[CD-1:0];
            P2: begin
              emit     = 1'b1;
              emit_rgb = {hr_q, hg_q, byte_data[CD-1:0]};
            end
            default: ;
          endcase
        end
      end
    end
  endgenerate

  always_comb begin
    phase_d   = phase_q;
    st_d      = st_q;
    cnt_d     = cnt_q;
    set_short = sof & (st_q == FILL);
    set_long  = byte_valid & ~byte_sof & (st_q == FULL);
    if (sof) begin
      st_d  = FILL;
      cnt_d = '0;
    end
    if (acc) begin
      unique case (ph)
        P0:      phase_d = P1;
        P1:      phase_d = P2;
        default: phase_d = P0;
      endcase
    end
    if (emit) begin
      cnt_d = cnt_e + 1'b1;
      if (cnt_e == LAST) st_d = FULL;
    end
    // A new error beats a simultaneous clear.
    eshort_d = set_short | (eshort_q & ~err_clr);
    elong_d  = set_long  | (elong_q  & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= P0;
      st_q     <= FILL_WAIT;
      cnt_q    <= '0;
      hr_q     <= '0;
      hg_q     <= '0;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      done_q   <= 1'b0;
      rgb_q    <= '0;
      eshort_q <= 1'b0;
      elong_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      hr_q     <= hr_d;
      hg_q     <= hg_d;
      valid_q  <= emit;
      sync_q   <= emit & (cnt_e == '0);
      done_q   <= emit & (cnt_e == LAST);
      if (emit) rgb_q <= emit_rgb;
      eshort_q <= eshort_d;
      elong_q  <= elong_d;
    end
  end

  assign pix_valid  = valid_q;
  assign pix_rgb    = rgb_q;
  assign pix_sync   = sync_q;
  assign frame_done = done_q;
  assign err_short  = eshort_q;
  assign err_long   = elong_q;

endmodule

// File: tb/tb_led_matrix_pixel_unpacker.sv
// Directed bench for led_matrix_pixel_unpacker (64x64 CD=4 and 1x1 CD=8).
// Drives bytes on negedge, samples outputs 1ns after posedge.
module tb_led_matrix_pixel_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        bv = 1'b0;
  logic [7:0]  bd = '0;
  logic        bs = 1'b0;
  logic        ec = 1'b0;
  logic        pv, sync, done, eshort, elong;
  logic [2:0][3:0] rgb;

  logic        bv8 = 1'b0;
  logic [7:0]  bd8 = '0;
  logic        bs8 = 1'b0;
  logic        ec8 = 1'b0;
  logic        pv8, sync8, done8, eshort8, elong8;
  logic [2:0][7:0] rgb8;

  int n_chk = 0;
  int n_pass = 0;
  int npix, nsync, ndone, done_at;

  always #5 clk = ~clk;

  led_matrix_pixel_unpacker #(
    .PANEL_ROWS(64), .PANEL_COLS(64), .COLOR_DEPTH(4)
  ) u_dut4 (
    .clk(clk), .rst(rst),
    .byte_valid(bv), .byte_data(bd), .byte_sof(bs),
    .err_clr(ec),
    .pix_valid(pv), .pix_rgb(rgb), .pix_sync(sync),
    .frame_done(done), .err_short(eshort), .err_long(elong)
  );

  led_matrix_pixel_unpacker #(
    .PANEL_ROWS(1), .PANEL_COLS(1), .COLOR_DEPTH(8)
  ) u_dut8 (
    .clk(clk), .rst(rst),
    .byte_valid(bv8), .byte_data(bd8), .byte_sof(bs8),
    .err_clr(ec8),
    .pix_valid(pv8), .pix_rgb(rgb8), .pix_sync(sync8),
    .frame_done(done8), .err_short(eshort8),
    .err_long(elong8)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] d,
                      input logic sof,
                      input logic clr);
    @(negedge clk);
    bv = 1'b1; bd = d; bs = sof; ec = clr;
    @(posedge clk);
    #1;
    if (pv) begin
      npix++;
      if (sync) nsync++;
      if (done) begin
        ndone++;
        done_at = npix - 1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bv = 1'b0; bs = 1'b0; ec = 1'b0;
  endtask

  task automatic send8(input logic [7:0] d,
                       input logic sof);
    @(negedge clk);
    bv8 = 1'b1; bd8 = d; bs8 = sof;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    npix = 0; nsync = 0; ndone = 0; done_at = -1;
  endtask

  initial begin
    clr_cnt();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // reset state
    chk("rst_pv", 32'(pv), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_sync", 32'(sync), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", {30'd0, eshort, elong}, 32'd0);

    // bytes before any SOF are dropped silently
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send(8'hCC, 1'b0, 1'b0);
    send(8'hDD, 1'b0, 1'b0);
    chk("presof_npix", 32'(npix), 32'd0);
    chk("presof_err", {30'd0, eshort, elong}, 32'd0);

    // CD=8 1x1: single pixel, sync and done together
    send8(8'hFF, 1'b1);
    chk("cd8_b0_pv", 32'(pv8), 32'd0);
    send8(8'h00, 1'b0);
    chk("cd8_b1_pv", 32'(pv8), 32'd0);
    send8(8'h80, 1'b0);
    chk("cd8_pv", 32'(pv8), 32'd1);
    chk("cd8_rgb", 32'(rgb8), 32'hFF0080);
    chk("cd8_sync", 32'(sync8), 32'd1);
    chk("cd8_done", 32'(done8), 32'd1);
    send8(8'h11, 1'b0);
    chk("cd8_extra_pv", 32'(pv8), 32'd0);
    chk("cd8_elong", 32'(elong8), 32'd1);
    chk("cd8_rgb_hold", 32'(rgb8), 32'hFF0080);
    @(negedge clk);
    bv8 = 1'b0;

    // full 64x64 frame, first bytes 12 34 56
    clr_cnt();
    send(8'h12, 1'b1, 1'b0);
    chk("f_b0_pv", 32'(pv), 32'd0);
    send(8'h34, 1'b0, 1'b0);
    chk("px0_pv", 32'(pv), 32'd1);
    chk("px0_rgb", 32'(rgb), 32'h123);
    chk("px0_sync", 32'(sync), 32'd1);
    send(8'h56, 1'b0, 1'b0);
    chk("px1_rgb", 32'(rgb), 32'h456);
    chk("px1_sync", 32'(sync), 32'd0);
    for (int k = 3; k < 6144; k++)
      send(8'(k), 1'b0, 1'b0);
    chk("frame_npix", 32'(npix), 32'd4096);
    chk("frame_nsync", 32'(nsync), 32'd1);
    chk("frame_ndone", 32'(ndone), 32'd1);
    chk("frame_done_at", 32'(done_at), 32'd4095);
    chk("frame_last_rgb", 32'(rgb), 32'hEFF);
    chk("frame_err", {30'd0, eshort, elong}, 32'd0);

    // overflow bytes dropped, err_long set
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    chk("ovf_npix", 32'(npix), 32'd4096);
    chk("ovf_elong", 32'(elong), 32'd1);
    chk("ovf_eshort", 32'(eshort), 32'd0);

    // clear and new overflow in same cycle: set wins
    send(8'h04, 1'b0, 1'b1);
    chk("clr_race_elong", 32'(elong), 32'd1);
    @(negedge clk);
    bv = 1'b0; ec = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_elong", 32'(elong), 32'd0);
    idle();

    // short frame: 100 pixels + 1 byte, then SOF
    clr_cnt();
    send(8'h00, 1'b1, 1'b0);
    for (int k = 1; k < 151; k++)
      send(8'(k), 1'b0, 1'b0);
    chk("short_npix", 32'(npix), 32'd100);
    chk("short_pre_err", 32'(eshort), 32'd0);
    send(8'hAB, 1'b1, 1'b0);
    chk("short_eshort", 32'(eshort), 32'd1);
    chk("short_sof_pv", 32'(pv), 32'd0);
    send(8'hCD, 1'b0, 1'b0);
    chk("restart_px0", 32'(rgb), 32'hABC);
    chk("restart_sync", 32'(sync), 32'd1);
    send(8'hEF, 1'b0, 1'b0);
    chk("restart_px1", 32'(rgb), 32'hDEF);
    chk("restart_cnt", 32'(u_dut4.cnt_q), 32'd2);
    chk("restart_elong", 32'(elong), 32'd0);

    // reset between P1 and P2
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    chk("pre_rst_pv", 32'(pv), 32'd1);
    @(negedge clk);
    bv = 1'b0; bs = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_pv", 32'(pv), 32'd0);
    chk("mid_rst_rgb", 32'(rgb), 32'd0);
    chk("mid_rst_err", {30'd0, eshort, elong}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clr_cnt();
    send(8'h33, 1'b0, 1'b0);
    send(8'h44, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    chk("post_rst_drop", 32'(npix), 32'd0);
    send(8'h12, 1'b1, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    chk("post_rst_px0", 32'(rgb), 32'h123);
    chk("post_rst_sync", 32'(sync), 32'd1);
    send(8'h56, 1'b0, 1'b0);
    chk("post_rst_px1", 32'(rgb), 32'h456);
    chk("post_rst_err", {30'd0, eshort, elong}, 32'd0);
    idle();
    @(posedge clk);
    #1;
    chk("idle_pv", 32'(pv), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
